// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: fetch state encoding, reset PC default,
// instruction size and the PC alignment helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned ALIGN_BITS       = $clog2(INSTR_BYTES);

    // A PC is misaligned when any byte-offset bit inside an instruction is set
    function automatic logic pc_misaligned(input logic [63:0] pc);
        return |pc[ALIGN_BITS-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Architectural PC register: async active-high reset to RESET_VAL,
// loads d when load is asserted, otherwise holds.
module pc_register #(
    parameter int unsigned         W         = 64,
    parameter logic [W-1:0]        RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // PC storage with load enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction per step over
// a req/ack memory handshake, presents it to decode with valid/ready, and
// takes the next PC verbatim from the next-PC logic on accept. A misaligned
// next PC parks the unit in a sticky fault state until reset.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [63:0]        NextPC,
    input  logic               InstrReady,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic               ImemReq,
    output logic [63:0]        ImemAddr,
    output logic [63:0]        CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic               Fault,
    output logic [63:0]        RetiredCount
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [63:0]  pc_q;
    logic         fetch_done;
    logic         accept;

    // Handshake qualifiers: acks only count while fetching, ready only while holding
    assign fetch_done = (state == FETCH) && ImemAck;
    assign accept     = (state == HOLD) && InstrReady;

    pc_register #(
        .W         (64),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk  (CLK),
        .rst  (Reset),
        .load (accept),
        .d    (NextPC),
        .q    (pc_q)
    );

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: if (ImemAck) state_next = HOLD;
            HOLD: begin
                if (InstrReady) begin
                    state_next = pc_misaligned(NextPC) ? FAULT : FETCH;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    // Outputs decoded from state only, so no input-to-output combinational path
    always_comb begin
        ImemReq    = (state == FETCH);
        InstrValid = (state == HOLD);
        Fault      = (state == FAULT);
        ImemAddr   = pc_q;
        CurrentPC  = pc_q;
    end

    // Capture the returned instruction word when the fetch completes
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Instruction <= '0;
        end else if (fetch_done) begin
            Instruction <= ImemData;
        end
    end

    // Count accepted instructions, wrapping at 64 bits
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RetiredCount <= '0;
        end else if (accept) begin
            RetiredCount <= RetiredCount + 64'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level reference
// model is compared against every DUT output on each falling clock edge,
// and directed scenarios add hand-computed literal expectations.
module tb_instr_fetch_unit;

    logic        CLK        = 1'b0;
    logic        Reset      = 1'b1;
    logic [63:0] NextPC     = '0;
    logic        InstrReady = 1'b0;
    logic        ImemAck    = 1'b0;
    logic [31:0] ImemData   = '0;

    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Fault;
    logic [63:0] RetiredCount;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_unit #(
        .RESET_PC (64'h0),
        .INSTR_W  (32)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .NextPC       (NextPC),
        .InstrReady   (InstrReady),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .CurrentPC    (CurrentPC),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .Fault        (Fault),
        .RetiredCount (RetiredCount)
    );

    always #5 CLK = ~CLK;

    // Reference model: "is an instruction on offer", "is the unit dead",
    // the PC, the last word received and the number handed over.
    logic [63:0] m_pc    = '0;
    logic [63:0] m_count = '0;
    logic [31:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_dead  = 1'b0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_pc    = 64'h0;
            m_count = 64'h0;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_dead  = 1'b0;
        end else if (m_dead) begin
            m_dead = 1'b1;
        end else if (!m_valid) begin
            if (ImemAck) begin
                m_instr = ImemData;
                m_valid = 1'b1;
            end
        end else if (InstrReady) begin
            m_count = m_count + 1;
            m_pc    = NextPC;
            m_valid = 1'b0;
            m_dead  = (NextPC % 4) != 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every cycle: all outputs against the model
    always @(negedge CLK) begin
        chk("m_ImemReq",      ImemReq,      !m_valid && !m_dead);
        chk("m_ImemAddr",     ImemAddr,     m_pc);
        chk("m_CurrentPC",    CurrentPC,    m_pc);
        chk("m_InstrValid",   InstrValid,   m_valid);
        chk("m_Fault",        Fault,        m_dead);
        chk("m_RetiredCount", RetiredCount, m_count);
        if (m_valid) chk("m_Instruction", Instruction, m_instr);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held over two edges
        step();
        step();
        chk("rst_valid", InstrValid, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_count", RetiredCount, 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_addr",  ImemAddr, 0);

        // Release with a same-cycle ack
        Reset    = 1'b0;
        ImemAck  = 1'b1;
        ImemData = 32'h8B020020;
        chk("first_req",  ImemReq, 1);
        chk("first_addr", ImemAddr, 0);
        step();
        ImemAck = 1'b0;
        chk("first_valid", InstrValid, 1);
        chk("first_instr", Instruction, 32'h8B020020);
        chk("first_pc",    CurrentPC, 0);

        // Sequential run, zero-wait memory, always ready
        InstrReady = 1'b1;
        ImemAck    = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            NextPC = 64'(4 * i);
            step();
            chk("seq_addr", ImemAddr, 64'(4 * i));
            chk("seq_req",  ImemReq, 1);
            if (i < 4) begin
                ImemData = 32'h1000_0000 + 32'(i);
                step();
            end
        end
        ImemAck    = 1'b0;
        InstrReady = 1'b0;
        chk("seq_count", RetiredCount, 4);

        // Memory wait of 3 cycles before the ack
        for (int i = 0; i < 3; i++) begin
            chk("wait_req",   ImemReq, 1);
            chk("wait_addr",  ImemAddr, 64'h10);
            chk("wait_valid", InstrValid, 0);
            step();
        end
        chk("wait_req4", ImemReq, 1);
        ImemAck  = 1'b1;
        ImemData = 32'hCAFE0010;
        step();
        ImemAck = 1'b0;
        chk("wait_instr", Instruction, 32'hCAFE0010);
        chk("wait_valid2", InstrValid, 1);

        // Back-pressure, with stray acks that must be ignored
        for (int i = 0; i < 5; i++) begin
            ImemAck  = i[0];
            ImemData = 32'hDEAD0000 + 32'(i);
            step();
            chk("bp_instr", Instruction, 32'hCAFE0010);
            chk("bp_pc",    CurrentPC, 64'h10);
            chk("bp_req",   ImemReq, 0);
            chk("bp_count", RetiredCount, 4);
        end
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        NextPC     = 64'h40;
        step();
        chk("bp_addr",   ImemAddr, 64'h40);
        chk("bp_count5", RetiredCount, 5);
        step();
        chk("ready_in_fetch_ignored", RetiredCount, 5);
        InstrReady = 1'b0;
        ImemAck    = 1'b1;
        ImemData   = 32'h11111111;
        step();
        ImemAck = 1'b0;

        // PC wrap at the top of the address space
        InstrReady = 1'b1;
        NextPC     = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk("wrap_hi", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        InstrReady = 1'b0;
        ImemAck    = 1'b1;
        ImemData   = 32'h22222222;
        step();
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        NextPC     = 64'h0;
        step();
        chk("wrap_lo",    ImemAddr, 64'h0);
        chk("wrap_count", RetiredCount, 7);

        // Misaligned branch target
        InstrReady = 1'b0;
        ImemAck    = 1'b1;
        ImemData   = 32'h33333333;
        step();
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        NextPC     = 64'h1002;
        step();
        chk("mis_fault", Fault, 1);
        chk("mis_req",   ImemReq, 0);
        chk("mis_pc",    CurrentPC, 64'h1002);
        chk("mis_count", RetiredCount, 8);
        for (int i = 0; i < 4; i++) begin
            ImemAck  = 1'b1;
            NextPC   = 64'h2000;
            step();
            chk("mis_sticky", Fault, 1);
            chk("mis_req_off", ImemReq, 0);
            chk("mis_count_hold", RetiredCount, 8);
            chk("mis_pc_hold", CurrentPC, 64'h1002);
        end

        // Asynchronous reset clears the fault
        #1 Reset = 1'b1;
        #1;
        chk("frst_fault", Fault, 0);
        chk("frst_addr",  ImemAddr, 0);
        chk("frst_count", RetiredCount, 0);
        ImemAck    = 1'b0;
        InstrReady = 1'b0;
        step();
        Reset = 1'b0;
        step();
        chk("refetch_req",  ImemReq, 1);
        chk("refetch_addr", ImemAddr, 0);

        // Reset in the middle of a memory wait, with acks during reset
        ImemAck  = 1'b1;
        ImemData = 32'h44444444;
        step();
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        NextPC     = 64'h80;
        step();
        InstrReady = 1'b0;
        step();
        chk("mw_addr", ImemAddr, 64'h80);
        #1 Reset = 1'b1;
        ImemAck  = 1'b1;
        ImemData = 32'hBAD0BAD0;
        #1;
        chk("mw_rst_addr",  ImemAddr, 0);
        chk("mw_rst_count", RetiredCount, 0);
        chk("mw_rst_valid", InstrValid, 0);
        chk("mw_rst_instr", Instruction, 0);
        step();
        step();
        ImemAck = 1'b0;
        Reset   = 1'b0;
        step();
        chk("mw_ack_ignored_valid", InstrValid, 0);
        chk("mw_ack_ignored_instr", Instruction, 0);
        chk("mw_req", ImemReq, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
